// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style responder: validates a trigger pulse, waits out the burst delay, then returns an
// echo whose width encodes distance_cm. Build option ULTRA_NO_TARGET_EN selects "no target" timeouts.
module ultrasonic_echo_emulator #(
   parameter int CLKS_PER_US    = 50,
   parameter int TRIG_MIN_US    = 10,
   parameter int BURST_DELAY_US = 200,
   parameter int US_PER_CM      = 58,
   parameter int MAX_CM         = 400,
   parameter int TIMEOUT_US     = 38000,
   parameter int HOLDOFF_US     = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trigger,
   input  logic [8:0] distance_cm,
   output logic       echo,
   output logic       busy,
   output logic       trig_err
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_TRIG_HI = 3'd1;
   localparam logic [2:0] S_DELAY   = 3'd2;
   localparam logic [2:0] S_ECHO    = 3'd3;
   localparam logic [2:0] S_HOLDOFF = 3'd4;

   localparam int PRE_W   = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam int CNT_MAX = (TIMEOUT_US > 131071) ? TIMEOUT_US : 131071;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLKS_PER_US - 1);
   // The cycle that detects the rising edge already counts as one high clock.
   localparam logic [PRE_W-1:0] PRE_ENTRY = PRE_W'((CLKS_PER_US == 1) ? 0 : 1);
   localparam logic [CNT_W-1:0] US_ENTRY  = CNT_W'((CLKS_PER_US == 1) ? 1 : 0);
   localparam logic [CNT_W-1:0] TRIG_MIN   = CNT_W'(TRIG_MIN_US);
   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(BURST_DELAY_US - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_US - 1);
   localparam logic [8:0]       MAX_D      = 9'(MAX_CM);

   function automatic logic [CNT_W-1:0] echo_width_us(input logic [8:0] d);
`ifdef ULTRA_NO_TARGET_EN
      if (d == 9'd0 || d > MAX_D) return CNT_W'(TIMEOUT_US);
      return CNT_W'(d) * CNT_W'(US_PER_CM);
`else
      logic [8:0] dc;
      dc = d;
      if (d > MAX_D) dc = MAX_D;
      else if (d == 9'd0) dc = 9'd1;
      return CNT_W'(dc) * CNT_W'(US_PER_CM);
`endif
   endfunction

   logic             sync1, trig_s, trig_d;
   logic [2:0]       state;
   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] us_cnt;
   logic [8:0]       dist_lat;
   logic [CNT_W-1:0] echo_w;
   logic             tick;

   assign tick   = (pre == PRE_LAST);
   assign echo_w = echo_width_us(dist_lat);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         trig_s   <= 1'b0;
         trig_d   <= 1'b0;
         state    <= S_IDLE;
         pre      <= '0;
         us_cnt   <= '0;
         echo     <= 1'b0;
         busy     <= 1'b0;
         trig_err <= 1'b0;
      end else begin
         sync1    <= trigger;
         trig_s   <= sync1;
         trig_d   <= trig_s;
         trig_err <= 1'b0;
         pre      <= tick ? '0 : pre + PRE_W'(1);
         case (state)
            S_IDLE: begin
               if (trig_s && !trig_d) begin
                  state  <= S_TRIG_HI;
                  pre    <= PRE_ENTRY;
                  us_cnt <= US_ENTRY;
               end else begin
                  pre    <= '0;
                  us_cnt <= '0;
               end
            end
            S_TRIG_HI: begin
               if (trig_s) begin
                  if (tick && us_cnt != '1) us_cnt <= us_cnt + CNT_W'(1);
               end else begin
                  pre    <= '0;
                  us_cnt <= '0;
                  if (us_cnt >= TRIG_MIN) begin
                     state    <= S_DELAY;
                     busy     <= 1'b1;
                     dist_lat <= distance_cm;
                  end else begin
                     state    <= S_IDLE;
                     trig_err <= 1'b1;
                  end
               end
            end
            // Timed states leave on a prescaler tick, so pre is already back at 0 on entry.
            S_DELAY: begin
               if (tick) begin
                  if (us_cnt == DELAY_LAST) begin
                     state  <= S_ECHO;
                     echo   <= 1'b1;
                     us_cnt <= '0;
                  end else begin
                     us_cnt <= us_cnt + CNT_W'(1);
                  end
               end
            end
            S_ECHO: begin
               if (tick) begin
                  if (us_cnt == echo_w - CNT_W'(1)) begin
                     state  <= S_HOLDOFF;
                     echo   <= 1'b0;
                     us_cnt <= '0;
                  end else begin
                     us_cnt <= us_cnt + CNT_W'(1);
                  end
               end
            end
            S_HOLDOFF: begin
               if (tick) begin
                  if (us_cnt == HOLD_LAST) begin
                     state  <= S_IDLE;
                     busy   <= 1'b0;
                     us_cnt <= '0;
                  end else begin
                     us_cnt <= us_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               echo  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Bench for ultrasonic_echo_emulator: cycle-level phase model with countdown timers plus
// directed and randomized trigger/distance stimulus; honours ULTRA_NO_TARGET_EN.
`timescale 1ns/1ps
module tb_ultrasonic_echo_emulator;
   localparam int CLKS  = 1;
   localparam int DLY   = 10;
   localparam int HOLD  = 20;
   localparam int MINUS = 10;
   localparam int UPC   = 58;
   localparam int MAXCM = 400;
   localparam int TMO   = 38000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       trigger = 1'b0;
   logic [8:0] distance_cm = 9'd0;
   logic       echo, busy, trig_err;

   ultrasonic_echo_emulator #(
      .CLKS_PER_US(CLKS), .BURST_DELAY_US(DLY), .HOLDOFF_US(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .trigger(trigger), .distance_cm(distance_cm),
      .echo(echo), .busy(busy), .trig_err(trig_err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int width_clks(input int d);
`ifdef ULTRA_NO_TARGET_EN
      if (d == 0 || d > MAXCM) return TMO * CLKS;
      return d * UPC * CLKS;
`else
      int dd = (d > MAXCM) ? MAXCM : ((d == 0) ? 1 : d);
      return dd * UPC * CLKS;
`endif
   endfunction

   // Behavioural model: phases with plain countdowns, trig_s = trigger delayed by two clocks.
   int   ph = 0, hi = 0, remain = 0, dlat = 0;
   logic m1 = 1'b0, m2 = 1'b0, m3 = 1'b0;
   logic exp_echo = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         ph = 0; hi = 0; remain = 0;
         m1 = 1'b0; m2 = 1'b0; m3 = 1'b0;
         exp_echo = 1'b0; exp_busy = 1'b0; exp_err = 1'b0;
      end else begin
         exp_err = 1'b0;
         case (ph)
            0: if (m2 && !m3) begin ph = 1; hi = 1; end
            1: begin
               if (m2) hi++;
               else if (hi >= MINUS * CLKS) begin
                  ph = 2; exp_busy = 1'b1; remain = DLY * CLKS; dlat = int'(distance_cm);
               end else begin
                  ph = 0; exp_err = 1'b1;
               end
            end
            2: begin
               remain--;
               if (remain == 0) begin ph = 3; exp_echo = 1'b1; remain = width_clks(dlat); end
            end
            3: begin
               remain--;
               if (remain == 0) begin ph = 4; exp_echo = 1'b0; remain = HOLD * CLKS; end
            end
            default: begin
               remain--;
               if (remain == 0) begin ph = 0; exp_busy = 1'b0; end
            end
         endcase
         m3 = m2; m2 = m1; m1 = trigger;
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         vectors++;
         if (echo !== exp_echo || busy !== exp_busy || trig_err !== exp_err) begin
            miscompares++;
            $display("FAIL cycle_cmp t=%0t echo/busy/err got %b%b%b expected %b%b%b",
                     $time, echo, busy, trig_err, exp_echo, exp_busy, exp_err);
         end
      end
   end

   // Edge monitor for the literal timing checks.
   int cyc = 0, echo_rise = 0, echo_fall = 0, busy_rise = 0, busy_fall = 0;
   int echo_pulses = 0, busy_rises = 0, err_pulses = 0;
   logic p_echo = 1'b0, p_busy = 1'b0;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (echo === 1'b1 && p_echo === 1'b0) begin echo_rise = cyc; echo_pulses++; end
      if (echo === 1'b0 && p_echo === 1'b1) echo_fall = cyc;
      if (busy === 1'b1 && p_busy === 1'b0) begin busy_rise = cyc; busy_rises++; end
      if (busy === 1'b0 && p_busy === 1'b1) busy_fall = cyc;
      if (trig_err === 1'b1) err_pulses++;
      p_echo = echo;
      p_busy = busy;
   end

   task automatic pulse(input int n);
      trigger = 1'b1;
      repeat (n) @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic wait_busy(input logic v, input int limit, input string name);
      for (int k = 0; k < limit && busy !== v; k++) @(negedge clk);
      if (busy !== v) check(name, busy, v);
   endtask

   task automatic wait_echo(input logic v, input int limit, input string name);
      for (int k = 0; k < limit && echo !== v; k++) @(negedge clk);
      if (echo !== v) check(name, echo, v);
   endtask

   task automatic run_meas(input int n, input int d, input int limit);
      distance_cm = 9'(d);
      pulse(n);
      wait_busy(1'b1, 20, "busy_rise_timeout");
      wait_busy(1'b0, limit, "busy_fall_timeout");
      repeat (3) @(negedge clk);
      #1;
   endtask

   int e0, b0, p0;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_echo", echo, 0);
      check("rst_busy", busy, 0);
      check("rst_err", trig_err, 0);
      chk_en = 1'b1;
      rst = 1'b0;
      repeat (5) @(negedge clk);

      p0 = echo_pulses;
      run_meas(12, 5, 1000);
      check("t1_delay", echo_rise - busy_rise, 10);
      check("t1_width", echo_fall - echo_rise, 290);
      check("t1_hold", busy_fall - echo_fall, 20);
      check("t1_pulses", echo_pulses - p0, 1);

      e0 = err_pulses; b0 = busy_rises; p0 = echo_pulses;
      pulse(5);
      repeat (10) @(negedge clk);
      #1;
      check("t2_err", err_pulses - e0, 1);
      check("t2_busy", busy_rises - b0, 0);
      check("t2_echo", echo_pulses - p0, 0);
      run_meas(12, 5, 1000);
      check("t2_width", echo_fall - echo_rise, 290);

      e0 = err_pulses;
      pulse(9);
      repeat (10) @(negedge clk);
      #1;
      check("min9_rejected", err_pulses - e0, 1);
      b0 = busy_rises;
      run_meas(10, 3, 1000);
      check("min10_accepted", busy_rises - b0, 1);
      check("min10_width", echo_fall - echo_rise, 174);

      run_meas(12, 500, 45000);
`ifdef ULTRA_NO_TARGET_EN
      check("t3_far_width", echo_fall - echo_rise, 38000);
`else
      check("t3_far_width", echo_fall - echo_rise, 23200);
      run_meas(12, 0, 1000);
      check("t3_zero_width", echo_fall - echo_rise, 58);
`endif

      p0 = echo_pulses; b0 = busy_rises;
      distance_cm = 9'd5;
      pulse(12);
      wait_echo(1'b1, 40, "t4_echo_rise_timeout");
      repeat (50) @(negedge clk);
      pulse(12);
      wait_echo(1'b0, 400, "t4_echo_fall_timeout");
      repeat (2) @(negedge clk);
      pulse(30);
      repeat (40) @(negedge clk);
      #1;
      check("t4_width", echo_fall - echo_rise, 290);
      check("t4_pulses", echo_pulses - p0, 1);
      check("t4_busy_rises", busy_rises - b0, 1);

      distance_cm = 9'd5;
      pulse(12);
      wait_echo(1'b1, 40, "t5_echo_rise_timeout");
      repeat (100) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_echo_after_rst", echo, 0);
      check("t5_busy_after_rst", busy, 0);
      repeat (5) @(negedge clk);
      run_meas(12, 5, 1000);
      check("t5_fresh_width", echo_fall - echo_rise, 290);

      distance_cm = 9'd5;
      pulse(12);
      wait_busy(1'b1, 20, "t6_busy_rise_timeout");
      repeat (3) @(negedge clk);
      distance_cm = 9'd100;
      wait_busy(1'b0, 2000, "t6_busy_fall_timeout");
      repeat (3) @(negedge clk);
      #1;
      check("t6_width", echo_fall - echo_rise, 290);

      for (int i = 0; i < 24; i++) begin
`ifdef ULTRA_NO_TARGET_EN
         distance_cm = 9'($urandom_range(1, 25));
`else
         distance_cm = 9'($urandom_range(0, 25));
`endif
         pulse($urandom_range(1, 16));
         repeat ($urandom_range(0, 300)) @(negedge clk);
      end
      wait_busy(1'b0, 5000, "rand_idle_timeout");
      repeat (30) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
